// File: rtl/tmr_hamming_scrub_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hamming_tmr_pkg : Hamming(7,4) types and helpers for the TMR scrub controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hamming_tmr_pkg;

  typedef logic [3:0] data_t;
  typedef logic [6:0] cw_t;
  typedef logic [2:0] syn_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VOTE = 2'd1,
    S_WB   = 2'd2
  } state_e;

  // Bit positions inside cw = {d3,d2,d1,p4,d0,p2,p1}
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P4_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  function automatic cw_t hamming_encode(input data_t d);
    cw_t cw;
    cw         = '0;
    cw[D0_POS] = d[0];
    cw[D1_POS] = d[1];
    cw[D2_POS] = d[2];
    cw[D3_POS] = d[3];
    cw[P1_POS] = d[0] ^ d[1] ^ d[3];
    cw[P2_POS] = d[0] ^ d[2] ^ d[3];
    cw[P4_POS] = d[1] ^ d[2] ^ d[3];
    return cw;
  endfunction

  function automatic syn_t hamming_syndrome(input cw_t cw);
    syn_t s;
    s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return s;
  endfunction

  // A non-zero syndrome is the 1-based position of the flipped bit
  function automatic cw_t hamming_correct(input cw_t cw, input syn_t s);
    cw_t r;
    r = cw;
    if (s != 3'd0) begin
      r[s - 3'd1] = ~cw[s - 3'd1];
    end
    return r;
  endfunction

  function automatic data_t hamming_data(input cw_t cw);
    return {cw[D3_POS], cw[D2_POS], cw[D1_POS], cw[D0_POS]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmr_hamming_scrub_ctrl_if.sv
// ----------------------------------------------------------------------------
// tmr_hamming_scrub_ctrl_if : host, read-return and fault-injection bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tmr_hamming_scrub_ctrl_if
  import hamming_tmr_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  data_t             wr_data;

  logic              rd_req;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  data_t             rd_data;
  logic              rd_corrected;

  logic              inj_valid;
  logic [1:0]        inj_sel;
  logic [ADDR_W-1:0] inj_addr;
  cw_t               inj_mask;

  logic              err_pulse;
  logic [CNT_W-1:0]  corr_count;
  logic              busy;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req, rd_addr,
    output inj_valid, inj_sel, inj_addr, inj_mask,
    input  wr_ready, rd_ready, rd_valid, rd_data, rd_corrected,
    input  err_pulse, corr_count, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req, rd_addr,
    input  inj_valid, inj_sel, inj_addr, inj_mask,
    output wr_ready, rd_ready, rd_valid, rd_data, rd_corrected,
    output err_pulse, corr_count, busy
  );

endinterface

`default_nettype wire

// File: rtl/tmr_hamming_scrub_ctrl_vote_dec.sv
// ----------------------------------------------------------------------------
// tmr_hamming_vote_dec : 2-of-3 bitwise vote followed by Hamming(7,4) decode
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tmr_hamming_vote_dec
  import hamming_tmr_pkg::*;
(
  input  cw_t   rep0,
  input  cw_t   rep1,
  input  cw_t   rep2,
  output cw_t   majority,
  output logic  mismatch,
  output syn_t  syndrome,
  output cw_t   corrected,
  output data_t data
);

  assign majority  = (rep0 & rep1) | (rep0 & rep2) | (rep1 & rep2);
  assign mismatch  = (rep0 != majority) || (rep1 != majority) || (rep2 != majority);
  assign syndrome  = hamming_syndrome(majority);
  assign corrected = hamming_correct(majority, syndrome);
  assign data      = hamming_data(corrected);

endmodule

`default_nettype wire

// File: rtl/tmr_hamming_scrub_ctrl.sv
// ----------------------------------------------------------------------------
// tmr_hamming_scrub_ctrl : three Hamming-protected replica banks, host access
// and background scrubbing through one shared vote/decode datapath. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tmr_hamming_scrub_ctrl
  import hamming_tmr_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int SCRUB_PERIOD = 64,
  parameter int CNT_W        = 8
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  tmr_hamming_scrub_ctrl_if.slave bus
);

  localparam int                TMR_W      = $clog2(SCRUB_PERIOD);
  localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(SCRUB_PERIOD - 1);

  cw_t               bank [3][DEPTH];
  state_e            state;
  logic [ADDR_W-1:0] op_addr;
  logic              op_scrub;
  logic [ADDR_W-1:0] scrub_ptr;
  logic [TMR_W-1:0]  scrub_timer;
  logic              scrub_pending;

  cw_t               maj_q;
  syn_t              syn_q;
  logic              mis_q;

  logic              rd_valid_q;
  data_t             rd_data_q;
  logic              rd_corr_q;
  logic              err_q;
  logic [CNT_W-1:0]  corr_cnt_q;

  logic              idle;
  logic              wr_fire;
  logic              rd_fire;
  logic              scrub_fire;
  logic              fix;
  cw_t               wr_cw;
  cw_t               vin0, vin1, vin2;
  cw_t               v_majority;
  logic              v_mismatch;
  syn_t              v_syndrome;
  cw_t               v_corrected;
  data_t             v_data;

  assign idle       = (state == S_IDLE);
  assign wr_fire    = idle && bus.wr_valid;
  assign rd_fire    = idle && !bus.wr_valid && bus.rd_req;
  assign scrub_fire = idle && !bus.wr_valid && !bus.rd_req && scrub_pending;
  assign fix        = (state == S_WB) && (mis_q || (syn_q != 3'd0));
  assign wr_cw      = hamming_encode(bus.wr_data);

  // In WB the voter sees the registered majority three times, so its
  // corrected/data outputs are the repair of the word captured in VOTE.
  always_comb begin
    vin0 = bank[0][op_addr];
    vin1 = bank[1][op_addr];
    vin2 = bank[2][op_addr];
    if (state == S_WB) begin
      vin0 = maj_q;
      vin1 = maj_q;
      vin2 = maj_q;
    end
  end

  tmr_hamming_vote_dec u_vote_dec (
    .rep0      (vin0),
    .rep1      (vin1),
    .rep2      (vin2),
    .majority  (v_majority),
    .mismatch  (v_mismatch),
    .syndrome  (v_syndrome),
    .corrected (v_corrected),
    .data      (v_data)
  );

  // Writes (host or write-back) take precedence over an injection on the same word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int a = 0; a < DEPTH; a++) begin
          bank[r][a] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int a = 0; a < DEPTH; a++) begin
          if (wr_fire && (bus.wr_addr == ADDR_W'(a))) begin
            bank[r][a] <= wr_cw;
          end else if (fix && (op_addr == ADDR_W'(a))) begin
            bank[r][a] <= v_corrected;
          end else if (bus.inj_valid && (bus.inj_sel == 2'(r)) &&
                       (bus.inj_addr == ADDR_W'(a))) begin
            bank[r][a] <= bank[r][a] ^ bus.inj_mask;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_addr       <= '0;
      op_scrub      <= 1'b0;
      scrub_ptr     <= '0;
      scrub_timer   <= TMR_RELOAD;
      scrub_pending <= 1'b0;
      maj_q         <= '0;
      syn_q         <= '0;
      mis_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      rd_corr_q     <= 1'b0;
      err_q         <= 1'b0;
      corr_cnt_q    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_corr_q  <= 1'b0;
      err_q      <= 1'b0;

      // Expiry in the same cycle as a scrub accept raises a fresh request
      if (scrub_fire) begin
        scrub_pending <= 1'b0;
      end
      if (scrub_timer == '0) begin
        scrub_timer   <= TMR_RELOAD;
        scrub_pending <= 1'b1;
      end else begin
        scrub_timer <= scrub_timer - TMR_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (rd_fire) begin
            op_addr  <= bus.rd_addr;
            op_scrub <= 1'b0;
            state    <= S_VOTE;
          end else if (scrub_fire) begin
            op_addr  <= scrub_ptr;
            op_scrub <= 1'b1;
            state    <= S_VOTE;
          end
        end
        S_VOTE: begin
          maj_q <= v_majority;
          syn_q <= v_syndrome;
          mis_q <= v_mismatch;
          state <= S_WB;
        end
        S_WB: begin
          if (fix) begin
            err_q <= 1'b1;
            if (corr_cnt_q != '1) begin
              corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            end
          end
          if (op_scrub) begin
            scrub_ptr <= scrub_ptr + ADDR_W'(1);
          end else begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= v_data;
            rd_corr_q  <= fix;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_ready     = idle;
  assign bus.rd_ready     = idle && !bus.wr_valid;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_corrected = rd_corr_q;
  assign bus.err_pulse    = err_q;
  assign bus.corr_count   = corr_cnt_q;
  assign bus.busy         = !idle;

endmodule

`default_nettype wire

// File: doc/tmr_hamming_scrub_ctrl.md
Name: tmr_hamming_scrub_ctrl

Overview:
Controller that owns three replicated banks of Hamming(7,4)-protected 4-bit words and time-shares a single vote/decode datapath between three users: host writes, host reads and a background scrubber.
Each read or scrub does the following, then writes the repaired codeword back to all three replicas:
- takes a bitwise 2-of-3 majority of the replicas;
- Hamming-decodes the majority;
- corrects any single-bit error.

The block sits between the host interface and the TMR+Hamming voter datapath. It also exposes a fault-injection port for verification.

Parameters:
DEPTH, 8, number of words per replica bank (power of 2, ≥2)
ADDR_W, $clog2(DEPTH), address width
SCRUB_PERIOD, 64, cycles between scrub requests (≥4)
CNT_W, 8, width of saturating correction counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  host write request
wr_ready  out  1  write accepted when wr_valid&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  4  write data
rd_req  in  1  host read request
rd_ready  out  1  read accepted when rd_req&rd_ready
rd_addr  in  ADDR_W  read address
rd_valid  out  1  one-cycle pulse, read result valid
rd_data  out  4  corrected read data
rd_corrected  out  1  qualifies rd_valid: a repair was applied
inj_valid  in  1  fault-injection strobe
inj_sel  in  2  replica 0..2 (3 = ignored)
inj_addr  in  ADDR_W  injection address
inj_mask  in  7  XOR mask applied to stored codeword
err_pulse  out  1  one-cycle pulse on any repair (read or scrub)
corr_count  out  CNT_W  saturating repair count
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - All replica words are 7'b0000000, a valid codeword for data 0.
  - FSM is IDLE; scrub pointer is 0; scrub timer is SCRUB_PERIOD-1; scrub_pending is 0.
  - All outputs are 0, except wr_ready = 1 and rd_ready = 1.
- Codeword layout, cw[6:0] = {d3,d2,d1,p4,d0,p2,p1}:
  - p1 = d0^d1^d3
  - p2 = d0^d2^d3
  - p4 = d1^d2^d3
- Syndrome s = {s4,s2,s1}:
  - s1 = cw0^cw2^cw4^cw6
  - s2 = cw1^cw2^cw5^cw6
  - s4 = cw3^cw4^cw5^cw6
  - s != 0 → flip cw[s-1].
- FSM states: IDLE, VOTE, WB.
- IDLE arbitration, fixed priority write > read > scrub:
  - rd_ready = IDLE & !wr_valid; wr_ready = IDLE.
  - Write: encode wr_data and write it to all three replicas at the accepting edge. FSM stays IDLE (one-cycle write).
  - Read accepted, or scrub_pending with no wr/rd present: latch address and source (host/scrub), go to VOTE. A scrub accept clears scrub_pending.
- VOTE: register the majority codeword, the syndrome, and mismatch = any replica != majority. Go to WB.
- WB:
  - fix = mismatch | (s != 0).
  - If fix: write the corrected codeword to all three replicas, pulse err_pulse, increment corr_count (saturates at all-ones).
  - Host source: rd_valid = 1, rd_data = corrected data bits, rd_corrected = fix.
  - Scrub source: increment the scrub pointer, wrapping DEPTH-1 → 0.
  - Go to IDLE.
- Read latency: rd_valid is asserted 2 cycles after the accept edge. Throughput is one read per 3 cycles.
- Scrub timer: free-running down-counter. At 0 it sets scrub_pending and reloads SCRUB_PERIOD-1. Expiry while scrub_pending is already set merges into the pending request; no queue.
- Injection:
  - Applied at any edge, in any state.
  - If the same edge writes the same addr/replica (host write or WB), the write wins and the injection is dropped.
  - inj_sel = 3 is a no-op.
- Hazards: a host write to the address currently in VOTE/WB is impossible, because wr_ready = 0 outside IDLE.
- Reset mid-operation: aborts immediately with no write-back, and all state returns to reset values.

Decomposition:
- Package hamming_tmr_pkg:
  - data_t (4b), cw_t (7b), state_e;
  - functions hamming_encode, hamming_syndrome, hamming_correct;
  - parity-position constants.
- Sub-module tmr_hamming_vote_dec (combinational):
  - inputs: three cw_t;
  - outputs: majority, mismatch, syndrome, corrected cw, data.
- The controller instantiates one tmr_hamming_vote_dec and holds the FSM, banks, timer and counters.

Test Plan:
1. Write addr2 data 4'b1010 → all replicas hold 7'b1010010. Read addr2 → rd_valid 2 cycles after accept, rd_data 4'b1010, rd_corrected 0, corr_count 0.
2. Inject inj_sel=1, addr2, mask 7'b0000001, then read → rd_data 4'b1010, rd_corrected 1, err_pulse once, replica1 addr2 restored to 7'b1010010, corr_count 1.
3. Inject mask 7'b0010000 into replicas 0 and 1 at addr2 (majority 7'b1000010, s=5) → rd_data 4'b1010, rd_corrected 1, all replicas 7'b1010010.
4. SCRUB_PERIOD=16, DEPTH=4, no host traffic, inject replica2 addr3 mask 7'b1000000 → within 4×16 cycles the scrub repairs addr3, err_pulse exactly once, corr_count +1, and rd_valid never pulses.
5. wr_valid and rd_req asserted in the same IDLE cycle, same addr, new data 4'b0110 → write accepted and rd_ready 0 that cycle. The read is accepted the next cycle and returns 4'b0110.
6. Assert rst_n=0 while in VOTE after an injection → busy, rd_valid and err_pulse drop asynchronously, corr_count 0, replicas read back 4'b0000.
